traffic_light_sequencer: RTL and testbench
==========================================

# traffic_light_sequencer

Parametrised multi-direction traffic light sequencer, the next generation of the team's single-approach controller. It drives red/yellow/green for `NUM_DIRS` approaches, one at a time, with programmable phase durations and an all-red clearance interval. Demand-driven direction selection and green extension skip idle approaches. A flashing-yellow maintenance mode is included. Sits at intersection top level, fed by debounced vehicle-detector inputs.

## Interface
- `NUM_DIRS`, 4: number of approaches (2..16).
- `GREEN_CYCLES`, 8: minimum green length in cycles (≥1).
- `YELLOW_CYCLES`, 3: yellow length (≥1).
- `ALL_RED_CYCLES`, 2: clearance length (≥1).
- `FLASH_CYCLES`, 4: half-period of flashing yellow (≥1).
- `CNT_W`, 8: phase counter width; must hold max(duration parameters)−1.
- `DIR_W`, derived: max(1, clog2(NUM_DIRS)).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, timing frozen: state, counter and outputs hold.
- `flash_mode`  in  1  maintenance request; priority over everything except reset.
- `demand`  in  NUM_DIRS  per-approach vehicle request, level, synchronous.
- `red`  out  NUM_DIRS  per-approach red lamp.
- `yellow`  out  NUM_DIRS  per-approach yellow lamp.
- `green`  out  NUM_DIRS  per-approach green lamp.
- `active_dir`  out  DIR_W  approach currently or last served.
- `phase`  out  2  00 ALL_RED, 01 GREEN, 10 YELLOW, 11 FLASH.

## Operation
- One clock domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values:
  - state ALL_RED, counter = ALL_RED_CYCLES−1.
  - `active_dir` = NUM_DIRS−1, so the first grant is approach 0 when nothing is pending.
  - `pending` = 0.
  - `red` = all ones, `yellow` = 0, `green` = 0, `phase` = 00.
- Pending latch: `pending[i]` is set on any cycle with `demand[i]`=1. It is held at 0 while approach i is in GREEN. Clear wins over set.
- Lamp mapping:
  - GREEN/YELLOW: only `active_dir` shows green/yellow; every other approach shows red.
  - ALL_RED: all red.
  - FLASH: red=0, green=0, yellow = all ones or all zeros per blink.
  - Exactly one lamp per approach is lit, except during the FLASH off half.
- Down-counter per phase. A phase ends on a cycle where counter==0 and `enable`=1. The next phase loads its own duration−1.
- ALL_RED end → GREEN. Selection uses a cyclic search starting at `active_dir`+1 (mod NUM_DIRS) and wrapping back to `active_dir` last:
  - Grant the first approach with `pending` set.
  - If none is pending, grant `active_dir`+1 mod NUM_DIRS.
  - The grant updates `active_dir`.
- GREEN end → YELLOW only if some other approach has `pending` set. Otherwise green extends: counter holds at 0 and GREEN is re-evaluated every enabled cycle.
- YELLOW end → ALL_RED.
- FLASH:
  - When `flash_mode`=1 in any state, the next edge enters FLASH with yellow on and counter = FLASH_CYCLES−1.
  - Yellow toggles each time the counter expires.
  - `enable` is ignored in FLASH.
  - When `flash_mode` drops, the next edge enters ALL_RED with the full count. `active_dir` is preserved.
- Reset mid-phase aborts immediately to the reset values. No lamp glitch: the outputs are flops.

## Timing
- Phase changes and lamp changes occur on the same rising edge; there is no extra output latency.
- An unextended green lasts exactly GREEN_CYCLES enabled cycles. Yellow lasts YELLOW_CYCLES, all-red lasts ALL_RED_CYCLES.
- A `demand` pulse is registered into `pending` at the edge where it is sampled. It can influence a selection or extension decision from the following cycle onward.
- During extension, if another approach's demand is sampled at edge k, `pending` is set at k and YELLOW begins at edge k+1 (given `enable`).
- `enable`=0 freezes everything except `pending` capture and FLASH entry.

## Test plan
- Reset, NUM_DIRS=4, no demand → 2 cycles all-red, then dir 0 green for 8 cycles. Green then extends indefinitely; `phase`=01, `active_dir`=0.
- `demand`=4'b1000 pulsed for 1 cycle during dir-0 extension → yellow on dir 0 next cycle for 3 cycles, 2 cycles all-red, then dir 3 green. Dirs 1 and 2 are skipped.
- `demand`=4'b0110 held during dir-3 green → after clearance dir 1 is granted (wrap search), then dir 2, then dir 1 again.
- `enable` low for 5 cycles mid-yellow → lamps and counter hold. Yellow totals 3 enabled cycles.
- `flash_mode` asserted mid-green → next edge all approaches yellow=1. Yellow toggles every 4 cycles. Release → 2 cycles all-red, then normal selection from the preserved `active_dir`.
- `reset_n` asserted asynchronously mid-green → `red`=4'b1111, `green`=0 and `phase`=00 before the next clock edge.

Source files
------------

// File: rtl/traffic_light_sequencer.sv
// Multi-approach traffic light sequencer: demand-driven approach selection,
// green extension while no other approach waits, all-red clearance and flashing-yellow maintenance.
module traffic_light_sequencer #(
  parameter int unsigned NUM_DIRS       = 4,
  parameter int unsigned GREEN_CYCLES   = 8,
  parameter int unsigned YELLOW_CYCLES  = 3,
  parameter int unsigned ALL_RED_CYCLES = 2,
  parameter int unsigned FLASH_CYCLES   = 4,
  parameter int unsigned CNT_W          = 8,
  localparam int unsigned DIR_W         = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                flash_mode,
  input  logic [NUM_DIRS-1:0] demand,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] green,
  output logic [DIR_W-1:0]    active_dir,
  output logic [1:0]          phase
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10,
    ST_FLASH   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LOAD   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LOAD = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD   = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [DIR_W-1:0] LAST_DIR     = DIR_W'(NUM_DIRS - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DIR_W-1:0]    dir_nxt;
  logic [NUM_DIRS-1:0] pending, pending_nxt;
  logic                blink, blink_nxt;
  logic [NUM_DIRS-1:0] red_nxt, yellow_nxt, green_nxt;
  logic [NUM_DIRS-1:0] dir_mask, nxt_mask;
  logic [DIR_W-1:0]    grant, idx;
  logic                found, other_pend, cnt_done;

  assign phase = state;

  // State, counter, pending latch and lamp registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ALL_RED;
      cnt        <= ALL_RED_LOAD;
      active_dir <= LAST_DIR;
      pending    <= '0;
      blink      <= 1'b0;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      active_dir <= dir_nxt;
      pending    <= pending_nxt;
      blink      <= blink_nxt;
      red        <= red_nxt;
      yellow     <= yellow_nxt;
      green      <= green_nxt;
    end
  end

  // Next-state, counter, selection and lamp decode
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_nxt    = active_dir;
    blink_nxt  = blink;
    red_nxt    = '1;
    yellow_nxt = '0;
    green_nxt  = '0;
    found      = 1'b0;
    idx        = '0;
    cnt_done   = (cnt == '0);

    dir_mask   = NUM_DIRS'(1) << active_dir;
    other_pend = |(pending & ~dir_mask);

    // Clear beats set for the approach currently showing green
    pending_nxt = pending | demand;
    if (state == ST_GREEN) pending_nxt = pending_nxt & ~dir_mask;

    // Cyclic search from active_dir+1, wrapping to active_dir last
    grant = DIR_W'((32'(active_dir) + 32'd1) % NUM_DIRS);
    for (int unsigned k = 1; k <= NUM_DIRS; k++) begin
      idx = DIR_W'((32'(active_dir) + k) % NUM_DIRS);
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end

    if (flash_mode) begin
      if (state != ST_FLASH) begin
        state_nxt = ST_FLASH;
        cnt_nxt   = FLASH_LOAD;
        blink_nxt = 1'b1;
      end else if (cnt_done) begin
        cnt_nxt   = FLASH_LOAD;
        blink_nxt = ~blink;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end else if (state == ST_FLASH) begin
      state_nxt = ST_ALL_RED;
      cnt_nxt   = ALL_RED_LOAD;
    end else if (enable) begin
      if (!cnt_done) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        unique case (state)
          ST_ALL_RED: begin
            state_nxt = ST_GREEN;
            cnt_nxt   = GREEN_LOAD;
            dir_nxt   = grant;
          end
          ST_GREEN: begin
            if (other_pend) begin
              state_nxt = ST_YELLOW;
              cnt_nxt   = YELLOW_LOAD;
            end
          end
          ST_YELLOW: begin
            state_nxt = ST_ALL_RED;
            cnt_nxt   = ALL_RED_LOAD;
          end
          default: state_nxt = ST_ALL_RED;
        endcase
      end
    end

    nxt_mask = NUM_DIRS'(1) << dir_nxt;
    unique case (state_nxt)
      ST_GREEN: begin
        red_nxt   = ~nxt_mask;
        green_nxt = nxt_mask;
      end
      ST_YELLOW: begin
        red_nxt    = ~nxt_mask;
        yellow_nxt = nxt_mask;
      end
      ST_FLASH: begin
        red_nxt    = '0;
        yellow_nxt = blink_nxt ? '1 : '0;
      end
      default: red_nxt = '1;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic checked every cycle against a phase/time model.
module tb_traffic_light_sequencer;

  localparam int N      = 4;
  localparam int G_DUR  = 8;
  localparam int Y_DUR  = 3;
  localparam int AR_DUR = 2;
  localparam int F_DUR  = 4;

  localparam int PH_AR = 0;
  localparam int PH_G  = 1;
  localparam int PH_Y  = 2;
  localparam int PH_F  = 3;

  logic         clock;
  logic         reset_n;
  logic         enable;
  logic         flash_mode;
  logic [N-1:0] demand;
  logic [N-1:0] red, yellow, green;
  logic [1:0]   active_dir;
  logic [1:0]   phase;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: current phase, enabled cycles spent in it, served approach
  int m_phase;
  int m_elapsed;
  int m_dir;
  bit m_on;
  bit m_pend[N];

  traffic_light_sequencer #(
    .NUM_DIRS(N), .GREEN_CYCLES(G_DUR), .YELLOW_CYCLES(Y_DUR),
    .ALL_RED_CYCLES(AR_DUR), .FLASH_CYCLES(F_DUR), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .flash_mode(flash_mode),
    .demand(demand), .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .phase(phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         en;
    bit         fm;
    logic [3:0] dem;
    int         n;
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic [1:0] ph;
    int         dir;
  } vec_t;

  vec_t tbl[$];

  function automatic int dur(input int ph);
    case (ph)
      PH_G:    return G_DUR;
      PH_Y:    return Y_DUR;
      PH_F:    return F_DUR;
      default: return AR_DUR;
    endcase
  endfunction

  task automatic model_reset();
    m_phase   = PH_AR;
    m_elapsed = 0;
    m_dir     = N - 1;
    m_on      = 1'b0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit fm, input logic [3:0] dem);
    bit old_pend[N];
    bit any_other;
    bit got;
    int order[$];
    int pick;
    old_pend  = m_pend;
    any_other = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = (m_phase == PH_G && i == m_dir) ? 1'b0 : (old_pend[i] | dem[i]);
      if (i != m_dir && old_pend[i]) any_other = 1'b1;
    end
    if (fm) begin
      if (m_phase != PH_F) begin
        m_phase = PH_F; m_elapsed = 0; m_on = 1'b1;
      end else if (m_elapsed == F_DUR - 1) begin
        m_elapsed = 0; m_on = !m_on;
      end else begin
        m_elapsed++;
      end
    end else if (m_phase == PH_F) begin
      m_phase = PH_AR; m_elapsed = 0;
    end else if (en) begin
      if (m_elapsed + 1 < dur(m_phase)) begin
        m_elapsed++;
      end else if (m_phase == PH_AR) begin
        for (int k = 1; k <= N; k++) order.push_back((m_dir + k) % N);
        pick = (m_dir + 1) % N;
        got  = 1'b0;
        foreach (order[j]) begin
          if (!got && old_pend[order[j]]) begin
            got = 1'b1; pick = order[j];
          end
        end
        m_dir = pick; m_phase = PH_G; m_elapsed = 0;
      end else if (m_phase == PH_G) begin
        if (any_other) begin
          m_phase = PH_Y; m_elapsed = 0;
        end
      end else begin
        m_phase = PH_AR; m_elapsed = 0;
      end
    end
  endtask

  task automatic compare(input string name, input logic [3:0] er, input logic [3:0] ey,
                         input logic [3:0] eg, input logic [1:0] eph, input int edir);
    total++;
    if (red === er && yellow === ey && green === eg && phase === eph && int'(active_dir) == edir) begin
      passed++;
    end else begin
      $display("FAIL %s cyc=%0d: got r=%b y=%b g=%b ph=%b dir=%0d, expected r=%b y=%b g=%b ph=%b dir=%0d",
               name, cyc, red, yellow, green, phase, active_dir, er, ey, eg, eph, edir);
    end
  endtask

  task automatic model_check(input string name);
    logic [3:0] er, ey, eg, mask;
    mask = 4'(1 << m_dir);
    er = 4'b1111; ey = 4'b0000; eg = 4'b0000;
    case (m_phase)
      PH_G:    begin er = ~mask; eg = mask; end
      PH_Y:    begin er = ~mask; ey = mask; end
      PH_F:    begin er = 4'b0000; ey = m_on ? 4'b1111 : 4'b0000; end
      default: er = 4'b1111;
    endcase
    compare(name, er, ey, eg, 2'(m_phase), m_dir);
  endtask

  // One clock: drive inputs away from the edge, step model at the edge, compare after it
  task automatic tick(input bit en, input bit fm, input logic [3:0] dem);
    enable = en; flash_mode = fm; demand = dem;
    @(posedge clock);
    cyc++;
    model_step(en, fm, dem);
    #1;
    model_check("model");
  endtask

  task automatic async_reset(input bit directed);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    if (directed) compare("async_reset", 4'b1111, 4'b0000, 4'b0000, 2'b00, 3);
    else model_check("async_reset_model");
    @(posedge clock);
    #1;
    model_check("held_reset_model");
    reset_n = 1'b1;
  endtask

  task automatic add(input bit en, input bit fm, input logic [3:0] dem, input int n,
                     input logic [3:0] r, input logic [3:0] y, input logic [3:0] g,
                     input logic [1:0] ph, input int dir);
    vec_t v;
    v.en = en; v.fm = fm; v.dem = dem; v.n = n;
    v.r = r; v.y = y; v.g = g; v.ph = ph; v.dir = dir;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] dem_r;
    bit         fm_r;

    add(1, 0, 4'b0000,  1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 3);
    add(1, 0, 4'b0000,  1, 4'b1110, 4'b0000, 4'b0001, 2'b01, 0);
    add(1, 0, 4'b0000,  7, 4'b1110, 4'b0000, 4'b0001, 2'b01, 0);
    add(1, 0, 4'b0000, 10, 4'b1110, 4'b0000, 4'b0001, 2'b01, 0);
    add(1, 0, 4'b1000,  1, 4'b1110, 4'b0000, 4'b0001, 2'b01, 0);
    add(1, 0, 4'b0000,  1, 4'b1110, 4'b0001, 4'b0000, 2'b10, 0);
    add(1, 0, 4'b0000,  2, 4'b1110, 4'b0001, 4'b0000, 2'b10, 0);
    add(1, 0, 4'b0000,  1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 0);
    add(1, 0, 4'b0000,  1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 0);
    add(1, 0, 4'b0000,  1, 4'b0111, 4'b0000, 4'b1000, 2'b01, 3);
    add(1, 0, 4'b0110,  7, 4'b0111, 4'b0000, 4'b1000, 2'b01, 3);
    add(1, 0, 4'b0110,  1, 4'b0111, 4'b1000, 4'b0000, 2'b10, 3);
    add(1, 0, 4'b0110,  3, 4'b1111, 4'b0000, 4'b0000, 2'b00, 3);
    add(1, 0, 4'b0110,  2, 4'b1101, 4'b0000, 4'b0010, 2'b01, 1);
    add(1, 0, 4'b0110,  8, 4'b1101, 4'b0010, 4'b0000, 2'b10, 1);
    add(1, 0, 4'b0110,  5, 4'b1011, 4'b0000, 4'b0100, 2'b01, 2);
    add(1, 0, 4'b0110,  8, 4'b1011, 4'b0100, 4'b0000, 2'b10, 2);
    add(1, 0, 4'b0110,  5, 4'b1101, 4'b0000, 4'b0010, 2'b01, 1);
    add(1, 0, 4'b0000,  8, 4'b1101, 4'b0010, 4'b0000, 2'b10, 1);
    add(1, 0, 4'b0000,  1, 4'b1101, 4'b0010, 4'b0000, 2'b10, 1);
    add(0, 0, 4'b0000,  5, 4'b1101, 4'b0010, 4'b0000, 2'b10, 1);
    add(1, 0, 4'b0000,  1, 4'b1101, 4'b0010, 4'b0000, 2'b10, 1);
    add(1, 0, 4'b0000,  1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 1);
    add(1, 0, 4'b0000,  2, 4'b1011, 4'b0000, 4'b0100, 2'b01, 2);
    add(1, 0, 4'b0000,  3, 4'b1011, 4'b0000, 4'b0100, 2'b01, 2);
    add(1, 1, 4'b0000,  1, 4'b0000, 4'b1111, 4'b0000, 2'b11, 2);
    add(1, 1, 4'b0000,  3, 4'b0000, 4'b1111, 4'b0000, 2'b11, 2);
    add(1, 1, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 2'b11, 2);
    add(0, 1, 4'b0000,  4, 4'b0000, 4'b1111, 4'b0000, 2'b11, 2);
    add(1, 0, 4'b0000,  1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 2);
    add(1, 0, 4'b0000,  1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 2);
    add(1, 0, 4'b0000,  1, 4'b0111, 4'b0000, 4'b1000, 2'b01, 3);
    add(1, 0, 4'b0000,  4, 4'b0111, 4'b0000, 4'b1000, 2'b01, 3);

    reset_n = 1'b0; enable = 1'b0; flash_mode = 1'b0; demand = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare("reset", 4'b1111, 4'b0000, 4'b0000, 2'b00, 3);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      repeat (tbl[i].n) tick(tbl[i].en, tbl[i].fm, tbl[i].dem);
      compare($sformatf("row%0d", i), tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].ph, tbl[i].dir);
    end

    // Asynchronous reset while dir 3 is green
    async_reset(1'b1);

    // Flash entry and exit both ignore a low enable
    tick(0, 1, 4'b0000);
    compare("flash_entry_en_low", 4'b0000, 4'b1111, 4'b0000, 2'b11, 3);
    tick(0, 0, 4'b0000);
    compare("flash_exit_en_low", 4'b1111, 4'b0000, 4'b0000, 2'b00, 3);
    tick(0, 0, 4'b0100);
    tick(1, 0, 4'b0000);
    tick(1, 0, 4'b0000);
    compare("pending_captured_en_low", 4'b1011, 4'b0000, 4'b0100, 2'b01, 2);

    fm_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 150) == 0) fm_r = !fm_r;
      dem_r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      tick($urandom_range(0, 7) != 0, fm_r, dem_r);
      if ($urandom_range(0, 600) == 0) async_reset(1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
